// File: rtl/wb_select_pipe_pkg.sv
// wb_select_pipe_pkg
//   Shared encodings for the writeback-select stage: load-size codes,
//   candidate source indices and the hard-wired zero register number.
package wb_select_pipe_pkg;

  typedef enum logic [1:0] {
    LD_BYTE  = 2'd0,
    LD_HALF  = 2'd1,
    LD_WORD  = 2'd2,
    LD_DWORD = 2'd3
  } ld_size_e;

  localparam int WB_ALU = 0;
  localparam int WB_MEM = 1;
  localparam int WB_PC4 = 2;
  localparam int WB_IMM = 3;

  // x0 is hard-wired to zero; writes to it are dropped.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_select_pipe_if.sv
// wb_select_pipe_if
//   Bundles the writeback-select request, pipeline controls and
//   register-file write results.
//   master : drives requests/controls (decode side), sees results
//   slave  : the wb_select_pipe stage itself
//   Request : in_valid, src_data, wb_sel, ld_size, ld_unsigned, ld_offset,
//             reg_write, rd_addr
//   Control : stall, flush
//   Result  : rf_we, rf_waddr, rf_wdata, out_valid, misalign, sel_err
interface wb_select_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int RADDR_W = 5
);
  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic                      in_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]          wb_sel;
  logic [1:0]                ld_size;
  logic                      ld_unsigned;
  logic [OFF_W-1:0]          ld_offset;
  logic                      reg_write;
  logic [RADDR_W-1:0]        rd_addr;
  logic                      stall;
  logic                      flush;

  logic                      rf_we;
  logic [RADDR_W-1:0]        rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic                      out_valid;
  logic                      misalign;
  logic                      sel_err;

  modport master (
    output in_valid, src_data, wb_sel, ld_size, ld_unsigned, ld_offset,
           reg_write, rd_addr, stall, flush,
    input  rf_we, rf_waddr, rf_wdata, out_valid, misalign, sel_err
  );

  modport slave (
    input  in_valid, src_data, wb_sel, ld_size, ld_unsigned, ld_offset,
           reg_write, rd_addr, stall, flush,
    output rf_we, rf_waddr, rf_wdata, out_valid, misalign, sel_err
  );

endinterface

// File: rtl/wb_select_pipe_load_extend.sv
// load_extend
//   Combinational load formatter: picks the byte/half/word/dword lane
//   addressed by offset, sign- or zero-extends it to DATA_W and flags
//   misaligned or unsupported sizes (result forced to 0 in that case).
//   data        in  : full memory word
//   ld_size     in  : LD_BYTE/LD_HALF/LD_WORD/LD_DWORD
//   ld_unsigned in  : 1 zero-extend, 0 sign-extend
//   offset      in  : low address bits
//   ext_data    out : extended lane
//   misalign    out : misaligned access or dword on a 32-bit datapath
module load_extend
  import wb_select_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [OFF_W-1:0]  offset,
  output logic [DATA_W-1:0] ext_data,
  output logic              misalign
);

  localparam bit HAS_DWORD = (DATA_W == 64);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] fill;
  logic              sbit;

  always_comb begin
    // Byte-granular shift lines the addressed lane up at bit 0; for
    // aligned halves/words this equals selecting lane offset/2 or offset/4.
    shifted  = data >> {offset, 3'b000};
    lane     = '0;
    fill     = '0;
    sbit     = 1'b0;
    misalign = 1'b0;
    case (ld_size)
      LD_BYTE: begin
        lane = DATA_W'(shifted[7:0]);
        sbit = shifted[7];
        fill = ~DATA_W'(8'hFF);
      end
      LD_HALF: begin
        misalign = offset[0];
        lane     = DATA_W'(shifted[15:0]);
        sbit     = shifted[15];
        fill     = ~DATA_W'(16'hFFFF);
      end
      LD_WORD: begin
        misalign = (offset[1:0] != 2'b00);
        lane     = DATA_W'(shifted[31:0]);
        sbit     = shifted[31];
        // On a 32-bit datapath this is all zeros: nothing to extend.
        fill     = ~DATA_W'(32'hFFFF_FFFF);
      end
      default: begin
        misalign = !HAS_DWORD || (offset != '0);
        lane     = shifted;
      end
    endcase
    if (misalign)
      ext_data = '0;
    else
      ext_data = lane | ((sbit && !ld_unsigned) ? fill : '0);
  end

endmodule

// File: rtl/wb_select_pipe.sv
// wb_select_pipe
//   Two-stage writeback select. Stage 1 captures the request verbatim;
//   stage 2 selects one of NUM_SRC candidates, formats memory loads and
//   registers the register-file write (enable, address, data) plus status.
//   clock in : rising-edge clock
//   reset in : synchronous active-high reset, clears every register
//   bus   slave modport of wb_select_pipe_if (request, stall/flush, results)
//   Priority per edge: reset > flush > stall > advance.
module wb_select_pipe
  import wb_select_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int MEM_IDX = WB_MEM,
  parameter int RADDR_W = 5
) (
  input logic            clock,
  input logic            reset,
  wb_select_pipe_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int OFF_W = $clog2(DATA_W / 8);
  // Only when the select field can encode more values than sources exist
  // is an out-of-range select possible.
  localparam bit SEL_CAN_ERR = ((2 ** SEL_W) > NUM_SRC);

  // Stage 1: captured request
  logic                      s1_valid;
  logic [NUM_SRC*DATA_W-1:0] s1_src;
  logic [SEL_W-1:0]          s1_sel;
  logic [1:0]                s1_size;
  logic                      s1_uns;
  logic [OFF_W-1:0]          s1_off;
  logic                      s1_rw;
  logic [RADDR_W-1:0]        s1_rd;

  // Stage 2: registered outputs
  logic                      r_valid;
  logic                      r_we;
  logic [RADDR_W-1:0]        r_waddr;
  logic [DATA_W-1:0]         r_wdata;
  logic                      r_mis;
  logic                      r_err;

  logic [DATA_W-1:0]         src_word;
  logic                      is_mem;
  logic                      sel_bad;
  logic [DATA_W-1:0]         le_data;
  logic                      le_mis;
  logic [DATA_W-1:0]         nxt_data;
  logic                      nxt_mis;
  logic                      nxt_err;
  logic                      nxt_we;

  always_comb begin
    src_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (s1_sel == SEL_W'(i))
        src_word = s1_src[i*DATA_W +: DATA_W];
    end
  end

  generate
    if (SEL_CAN_ERR) begin : g_sel_chk
      assign sel_bad = (s1_sel >= SEL_W'(NUM_SRC));
    end else begin : g_sel_full
      assign sel_bad = 1'b0;
    end
  endgenerate

  assign is_mem = (s1_sel == SEL_W'(MEM_IDX));

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .data        (src_word),
    .ld_size     (s1_size),
    .ld_unsigned (s1_uns),
    .offset      (s1_off),
    .ext_data    (le_data),
    .misalign    (le_mis)
  );

  always_comb begin
    nxt_data = src_word;
    if (sel_bad)
      nxt_data = '0;
    else if (is_mem)
      nxt_data = le_data;
  end

  // Status flags describe a real instruction, so bubbles never raise them.
  assign nxt_mis = s1_valid && is_mem && le_mis;
  assign nxt_err = s1_valid && sel_bad;
  assign nxt_we  = s1_valid && s1_rw && (s1_rd != RADDR_W'(REG_ZERO))
                   && !nxt_mis && !nxt_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_src   <= '0;
      s1_sel   <= '0;
      s1_size  <= '0;
      s1_uns   <= 1'b0;
      s1_off   <= '0;
      s1_rw    <= 1'b0;
      s1_rd    <= '0;
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_mis    <= 1'b0;
      r_err    <= 1'b0;
    end else if (bus.flush) begin
      // Only validity and status are killed; data/address may stay stale.
      s1_valid <= 1'b0;
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_mis    <= 1'b0;
      r_err    <= 1'b0;
    end else if (!bus.stall) begin
      s1_valid <= bus.in_valid;
      s1_src   <= bus.src_data;
      s1_sel   <= bus.wb_sel;
      s1_size  <= bus.ld_size;
      s1_uns   <= bus.ld_unsigned;
      s1_off   <= bus.ld_offset;
      s1_rw    <= bus.reg_write;
      s1_rd    <= bus.rd_addr;
      r_valid  <= s1_valid;
      r_we     <= nxt_we;
      r_waddr  <= s1_rd;
      r_wdata  <= nxt_data;
      r_mis    <= nxt_mis;
      r_err    <= nxt_err;
    end
  end

  assign bus.rf_we     = r_we;
  assign bus.rf_waddr  = r_waddr;
  assign bus.rf_wdata  = r_wdata;
  assign bus.out_valid = r_valid;
  assign bus.misalign  = r_mis;
  assign bus.sel_err   = r_err;

endmodule

// File: tb/tb_wb_select_pipe.sv
// tb_wb_select_pipe
//   Directed bench for wb_select_pipe across three builds:
//   b0 (DATA_W=32, NUM_SRC=4), b1 (DATA_W=32, NUM_SRC=3), b2 (DATA_W=64, NUM_SRC=4).
module tb_wb_select_pipe;

  logic clock;
  logic reset;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [31:0] MEM0 = 32'h80FF_7F01;
  localparam logic [31:0] PC40 = 32'h0000_1004;
  localparam logic [31:0] IMM0 = 32'hFFFF_FFF0;
  localparam logic [63:0] MEM2 = 64'h8123_4567_89AB_CDEF;

  wb_select_pipe_if #(.DATA_W(32), .NUM_SRC(4), .RADDR_W(5)) bus0 ();
  wb_select_pipe_if #(.DATA_W(32), .NUM_SRC(3), .RADDR_W(5)) bus1 ();
  wb_select_pipe_if #(.DATA_W(64), .NUM_SRC(4), .RADDR_W(5)) bus2 ();

  wb_select_pipe #(.DATA_W(32), .NUM_SRC(4), .MEM_IDX(1), .RADDR_W(5)) dut0 (
    .clock (clock), .reset (reset), .bus (bus0));
  wb_select_pipe #(.DATA_W(32), .NUM_SRC(3), .MEM_IDX(1), .RADDR_W(5)) dut1 (
    .clock (clock), .reset (reset), .bus (bus1));
  wb_select_pipe #(.DATA_W(64), .NUM_SRC(4), .MEM_IDX(1), .RADDR_W(5)) dut2 (
    .clock (clock), .reset (reset), .bus (bus2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk0(input string tag, input bit we, input logic [4:0] waddr,
                      input logic [31:0] data, input bit valid, input bit mis);
    chk({tag, ".we"},    bus0.rf_we,     we);
    chk({tag, ".waddr"}, bus0.rf_waddr,  waddr);
    chk({tag, ".wdata"}, bus0.rf_wdata,  data);
    chk({tag, ".valid"}, bus0.out_valid, valid);
    chk({tag, ".mis"},   bus0.misalign,  mis);
    chk({tag, ".serr"},  bus0.sel_err,   1'b0);
  endtask

  task automatic drive0(input int sel, input int size, input bit uns, input int off,
                        input int rd, input logic [31:0] alu);
    bus0.in_valid    = 1'b1;
    bus0.wb_sel      = 2'(sel);
    bus0.ld_size     = 2'(size);
    bus0.ld_unsigned = uns;
    bus0.ld_offset   = 2'(off);
    bus0.reg_write   = 1'b1;
    bus0.rd_addr     = 5'(rd);
    bus0.src_data    = {IMM0, PC40, MEM0, alu};
  endtask

  task automatic op0(input string tag, input int sel, input int size, input bit uns,
                     input int off, input int rd, input bit we, input logic [31:0] data,
                     input bit mis);
    drive0(sel, size, uns, off, rd, 32'h0000_1234);
    step();
    bus0.in_valid = 1'b0;
    step();
    chk0(tag, we, 5'(rd), data, 1'b1, mis);
  endtask

  task automatic op2(input string tag, input int size, input bit uns, input int off,
                     input bit we, input logic [63:0] data, input bit mis);
    bus2.in_valid    = 1'b1;
    bus2.wb_sel      = 2'd1;
    bus2.ld_size     = 2'(size);
    bus2.ld_unsigned = uns;
    bus2.ld_offset   = 3'(off);
    bus2.reg_write   = 1'b1;
    bus2.rd_addr     = 5'd9;
    bus2.src_data    = {64'h3, 64'h2, MEM2, 64'h1};
    step();
    bus2.in_valid = 1'b0;
    step();
    chk({tag, ".we"},    bus2.rf_we,     we);
    chk({tag, ".wdata"}, bus2.rf_wdata,  data);
    chk({tag, ".mis"},   bus2.misalign,  mis);
    chk({tag, ".valid"}, bus2.out_valid, 1'b1);
  endtask

  initial begin
    bus0.in_valid = 0; bus0.src_data = '0; bus0.wb_sel = '0; bus0.ld_size = '0;
    bus0.ld_unsigned = 0; bus0.ld_offset = '0; bus0.reg_write = 0; bus0.rd_addr = '0;
    bus0.stall = 0; bus0.flush = 0;
    bus1.in_valid = 0; bus1.src_data = '0; bus1.wb_sel = '0; bus1.ld_size = '0;
    bus1.ld_unsigned = 0; bus1.ld_offset = '0; bus1.reg_write = 0; bus1.rd_addr = '0;
    bus1.stall = 0; bus1.flush = 0;
    bus2.in_valid = 0; bus2.src_data = '0; bus2.wb_sel = '0; bus2.ld_size = '0;
    bus2.ld_unsigned = 0; bus2.ld_offset = '0; bus2.reg_write = 0; bus2.rd_addr = '0;
    bus2.stall = 0; bus2.flush = 0;

    // Reset held 2 cycles with a live request on the inputs.
    reset = 1'b1;
    drive0(0, 2, 0, 0, 5, 32'h0000_1234);
    step();
    step();
    chk0("rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    bus0.in_valid = 1'b0;
    reset = 1'b0;
    step();
    chk("rst.s1_cleared", bus0.out_valid, 1'b0);

    // Select and load formatting on the 32-bit, 4-source build.
    op0("alu",        0, 2, 0, 0, 5, 1'b1, 32'h0000_1234, 1'b0);
    op0("lb_s_off3",  1, 0, 0, 3, 7, 1'b1, 32'hFFFF_FF80, 1'b0);
    op0("lb_u_off3",  1, 0, 1, 3, 7, 1'b1, 32'h0000_0080, 1'b0);
    op0("lh_s_off2",  1, 1, 0, 2, 8, 1'b1, 32'hFFFF_80FF, 1'b0);
    op0("lh_u_off2",  1, 1, 1, 2, 8, 1'b1, 32'h0000_80FF, 1'b0);
    op0("lb_s_off1",  1, 0, 0, 1, 9, 1'b1, 32'h0000_007F, 1'b0);
    op0("lw_off0",    1, 2, 0, 0, 10, 1'b1, 32'h80FF_7F01, 1'b0);
    op0("lh_off1",    1, 1, 0, 1, 11, 1'b0, 32'h0, 1'b1);
    op0("lw_off2",    1, 2, 0, 2, 12, 1'b0, 32'h0, 1'b1);
    op0("ld_on32",    1, 3, 0, 0, 13, 1'b0, 32'h0, 1'b1);
    op0("pc4_ignore", 2, 0, 0, 3, 14, 1'b1, 32'h0000_1004, 1'b0);
    op0("imm",        3, 0, 1, 1, 15, 1'b1, 32'hFFFF_FFF0, 1'b0);
    op0("x0",         0, 2, 0, 0, 0, 1'b0, 32'h0000_1234, 1'b0);

    // Stall for 3 cycles with B in stage 1: A holds, then B, C once each.
    drive0(0, 2, 0, 0, 1, 32'h0000_000A);
    step();
    drive0(0, 2, 0, 0, 2, 32'h0000_000B);
    step();
    chk0("stl.a0", 1'b1, 5'd1, 32'hA, 1'b1, 1'b0);
    drive0(0, 2, 0, 0, 3, 32'h0000_000C);
    bus0.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk0($sformatf("stl.hold%0d", i), 1'b1, 5'd1, 32'hA, 1'b1, 1'b0);
    end
    bus0.stall = 1'b0;
    step();
    chk0("stl.b", 1'b1, 5'd2, 32'hB, 1'b1, 1'b0);
    bus0.in_valid = 1'b0;
    step();
    chk0("stl.c", 1'b1, 5'd3, 32'hC, 1'b1, 1'b0);
    step();
    chk("stl.end.we", bus0.rf_we, 1'b0);
    chk("stl.end.valid", bus0.out_valid, 1'b0);

    // Flush together with stall: A in stage 1, B on the inputs.
    drive0(0, 2, 0, 0, 4, 32'h0000_AAAA);
    step();
    drive0(0, 2, 0, 0, 6, 32'h0000_BBBB);
    bus0.flush = 1'b1;
    bus0.stall = 1'b1;
    step();
    chk("fl.we", bus0.rf_we, 1'b0);
    chk("fl.valid", bus0.out_valid, 1'b0);
    bus0.flush = 1'b0;
    bus0.stall = 1'b0;
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("fl.after%0d.we", i), bus0.rf_we, 1'b0);
      chk($sformatf("fl.after%0d.valid", i), bus0.out_valid, 1'b0);
    end

    // Flush also clears a misalign flag sitting on the outputs.
    op0("fl.pre_mis", 1, 1, 0, 1, 11, 1'b0, 32'h0, 1'b1);
    bus0.flush = 1'b1;
    step();
    bus0.flush = 1'b0;
    chk("fl.mis", bus0.misalign, 1'b0);
    chk("fl.mis.valid", bus0.out_valid, 1'b0);

    // Three-source build: wb_sel=3 is out of range.
    bus1.in_valid  = 1'b1;
    bus1.wb_sel    = 2'd3;
    bus1.reg_write = 1'b1;
    bus1.rd_addr   = 5'd7;
    bus1.src_data  = {32'h2222_2222, MEM0, 32'h1111_1111};
    step();
    bus1.wb_sel = 2'd2;
    step();
    chk("serr.flag",  bus1.sel_err,   1'b1);
    chk("serr.we",    bus1.rf_we,     1'b0);
    chk("serr.wdata", bus1.rf_wdata,  32'h0);
    chk("serr.valid", bus1.out_valid, 1'b1);
    bus1.in_valid = 1'b0;
    step();
    chk("src2.flag",  bus1.sel_err,   1'b0);
    chk("src2.we",    bus1.rf_we,     1'b1);
    chk("src2.wdata", bus1.rf_wdata,  32'h2222_2222);

    // 64-bit build.
    op2("ld_off0",    3, 0, 0, 1'b1, 64'h8123_4567_89AB_CDEF, 1'b0);
    op2("lw_s_off4",  2, 0, 4, 1'b1, 64'hFFFF_FFFF_8123_4567, 1'b0);
    op2("lw_u_off4",  2, 1, 4, 1'b1, 64'h0000_0000_8123_4567, 1'b0);
    op2("ld_off4",    3, 0, 4, 1'b0, 64'h0, 1'b1);
    op2("lb_u_off7",  0, 1, 7, 1'b1, 64'h0000_0000_0000_0081, 1'b0);
    op2("lb_s_off7",  0, 0, 7, 1'b1, 64'hFFFF_FFFF_FFFF_FF81, 1'b0);
    op2("lh_s_off6",  1, 0, 6, 1'b1, 64'hFFFF_FFFF_FFFF_8123, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
